fetch_branch_unit: RTL and testbench

//  PC/fetch stage of the single-cycle RV32 core: the consumer of ALU results (ALUResult, zero, less).
//  - Holds the PC and drives the synchronous instruction ROM.
//  - Resolves branch/jal/jalr outcome from the ALU flags and selects the next PC.
//  - Presents the instruction, its PC and the link address (PC+4) to decode/writeback.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/branch_resolve.sv | 42 ++++
 rtl/fetch_branch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_branch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared RV32 core definitions: branch-type codes, default
//               reset PC and fetch-stage state encoding.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [2:0] BT_BEQ  = 3'b000;
    localparam logic [2:0] BT_BNE  = 3'b001;
    localparam logic [2:0] BT_BLT  = 3'b100;
    localparam logic [2:0] BT_BGE  = 3'b101;
    localparam logic [2:0] BT_BLTU = 3'b110;
    localparam logic [2:0] BT_BGEU = 3'b111;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int FS_W = 2;
    localparam logic [FS_W-1:0] FS_BOOT = 2'd0;
    localparam logic [FS_W-1:0] FS_RUN  = 2'd1;
    localparam logic [FS_W-1:0] FS_HALT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Combinational branch/jump resolution: taken flag, target
//               address and target misalignment.
// Revision    : 1.0
// ============================================================================
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_branch,
    input  logic [2:0]  i_branch_type,
    input  logic        i_jump,
    input  logic        i_jalr,
    input  logic        i_zero,
    input  logic        i_less,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_imm32,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic        o_misalign
);

    logic w_cond;

    // The ALU flags already carry the correct polarity for each compare kind.
    always_comb begin
        w_cond = 1'b0;
        case (i_branch_type)
            BT_BEQ, BT_BNE:                   w_cond = i_zero;
            BT_BLT, BT_BGE, BT_BLTU, BT_BGEU: w_cond = i_less;
            default:                          w_cond = 1'b0;
        endcase
    end

    assign o_taken    = i_jump | (i_branch & w_cond);
    assign o_target   = (i_jump & i_jalr) ? i_alu_result : (i_pc + i_imm32);
    assign o_misalign = o_taken & (o_target[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_branch_unit
// Description : PC/fetch stage of the single-cycle RV32 core; holds the PC,
//               drives the synchronous instruction ROM and applies branches.
// Revision    : 1.0
// ============================================================================
module fetch_branch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               Branch,
    input  logic [2:0]         BranchType,
    input  logic               Jump,
    input  logic               Jalr,
    input  logic               zero,
    input  logic               less,
    input  logic [31:0]        ALUResult,
    input  logic [31:0]        imm32,
    output logic               redirect,
    output logic               misalign_err,
    output logic [31:0]        retired
);

    logic [FS_W-1:0] r_state;
    logic [FS_W-1:0] w_state_next;
    logic [31:0]     r_pc;
    logic [31:0]     w_pc_next;
    logic [31:0]     w_pc_plus4;
    logic [31:0]     r_retired;
    logic [31:0]     w_retired_next;
    logic            r_instr_valid;
    logic            r_misalign_err;
    logic            w_misalign_err_next;
    logic            w_redirect;
    logic [31:0]     w_fetch_pc;
    logic            w_taken;
    logic            w_misalign;
    logic [31:0]     w_target;
    logic            w_unused_fetch_bits;

    branch_resolve u_branch_resolve (
        .i_pc          (r_pc),
        .i_branch      (Branch),
        .i_branch_type (BranchType),
        .i_jump        (Jump),
        .i_jalr        (Jalr),
        .i_zero        (zero),
        .i_less        (less),
        .i_alu_result  (ALUResult),
        .i_imm32       (imm32),
        .o_taken       (w_taken),
        .o_target      (w_target),
        .o_misalign    (w_misalign)
    );

    assign w_pc_plus4 = r_pc + 32'd4;

    // w_fetch_pc is the address the ROM samples this edge; defaults to
    // re-reading the current PC so held/halted instructions stay put.
    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_retired_next      = r_retired;
        w_misalign_err_next = r_misalign_err;
        w_fetch_pc          = r_pc;
        w_redirect          = 1'b0;
        case (r_state)
            FS_BOOT: begin
                w_state_next = FS_RUN;
                w_fetch_pc   = RESET_PC;
            end
            FS_RUN: begin
                if (!stall) begin
                    w_redirect = w_taken;
                    w_fetch_pc = w_taken ? w_target : w_pc_plus4;
                    if (w_misalign) begin
                        w_state_next        = FS_HALT;
                        w_misalign_err_next = 1'b1;
                    end else begin
                        w_pc_next      = w_fetch_pc;
                        w_retired_next = r_retired + 32'd1;
                    end
                end
            end
            FS_HALT: begin
                w_state_next = FS_HALT;
            end
            default: begin
                w_state_next = FS_BOOT;
            end
        endcase
        if (rst) begin
            w_fetch_pc = RESET_PC;
            w_redirect = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= FS_BOOT;
            r_pc           <= RESET_PC;
            r_retired      <= 32'd0;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_retired      <= w_retired_next;
            r_instr_valid  <= (w_state_next == FS_RUN);
            r_misalign_err <= w_misalign_err_next;
        end
    end

    assign w_unused_fetch_bits = ^{w_fetch_pc[31:IMEM_AW+2], w_fetch_pc[1:0]};

    assign imem_addr    = w_fetch_pc[IMEM_AW+1:2];
    assign instr        = imem_rdata;
    assign instr_valid  = r_instr_valid;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign redirect     = w_redirect;
    assign misalign_err = r_misalign_err;
    assign retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_branch_unit
// Description : Self-checking bench for fetch_branch_unit: directed scenarios
//               with literal expectations plus randomized traffic against a
//               behavioural fetch model.
// Revision    : 1.0
// ============================================================================
module tb_fetch_branch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam int          C_AW       = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [C_AW-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic [31:0]     pc;
    logic [31:0]     pc_plus4;
    logic            Branch;
    logic [2:0]      BranchType;
    logic            Jump;
    logic            Jalr;
    logic            zero;
    logic            less;
    logic [31:0]     ALUResult;
    logic [31:0]     imm32;
    logic            redirect;
    logic            misalign_err;
    logic [31:0]     retired;

    fetch_branch_unit #(.RESET_PC(C_RESET_PC), .IMEM_AW(C_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .Branch       (Branch),
        .BranchType   (BranchType),
        .Jump         (Jump),
        .Jalr         (Jalr),
        .zero         (zero),
        .less         (less),
        .ALUResult    (ALUResult),
        .imm32        (imm32),
        .redirect     (redirect),
        .misalign_err (misalign_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:(1<<C_AW)-1];
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {P_BOOT, P_RUN, P_HALT} phase_t;
    phase_t      m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic        m_err;
    logic        preload;
    logic        chk_en;

    function automatic logic f_taken(input logic br, input logic [2:0] bt, input logic jmp,
                                     input logic z, input logic l);
        if (jmp) return 1'b1;
        if (!br) return 1'b0;
        case (bt)
            3'b000, 3'b001:                 return z;
            3'b100, 3'b101, 3'b110, 3'b111: return l;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_target(input logic [31:0] p, input logic jmp, input logic jr,
                                             input logic [31:0] alu, input logic [31:0] imm);
        if (jmp && jr) return alu;
        return p + imm;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] base;
        logic [31:0] tgt;
        base = preload ? 32'hFFFF_FFFF : m_retired;
        tgt  = f_target(m_pc, Jump, Jalr, ALUResult, imm32);
        if (rst) begin
            m_phase   <= P_BOOT;
            m_pc      <= C_RESET_PC;
            m_retired <= 32'd0;
            m_err     <= 1'b0;
        end else begin
            m_retired <= base;
            case (m_phase)
                P_BOOT: m_phase <= P_RUN;
                P_RUN: begin
                    if (!stall) begin
                        if (f_taken(Branch, BranchType, Jump, zero, less)) begin
                            if (tgt % 4 != 0) begin
                                m_err   <= 1'b1;
                                m_phase <= P_HALT;
                            end else begin
                                m_pc      <= tgt;
                                m_retired <= base + 32'd1;
                            end
                        end else begin
                            m_pc      <= m_pc + 32'd4;
                            m_retired <= base + 32'd1;
                        end
                    end
                end
                default: m_phase <= P_HALT;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin : compare
            logic        run;
            logic        tk;
            logic [31:0] tgt;
            logic [31:0] fpc;
            run = (m_phase == P_RUN);
            tk  = f_taken(Branch, BranchType, Jump, zero, less);
            tgt = f_target(m_pc, Jump, Jalr, ALUResult, imm32);
            if (rst || m_phase == P_BOOT) fpc = C_RESET_PC;
            else if (!run || stall)       fpc = m_pc;
            else                          fpc = tk ? tgt : m_pc + 32'd4;
            check("instr_valid", {31'd0, instr_valid}, {31'd0, run});
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("retired", retired, m_retired);
            check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
            check("redirect", {31'd0, redirect}, {31'd0, (!rst && run && tk && !stall)});
            check("imem_addr", {18'd0, imem_addr}, {18'd0, fpc[C_AW+1:2]});
            if (run) check("instr", instr, rom[m_pc[C_AW+1:2]]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        stall = 0; Branch = 0; BranchType = 3'b000; Jump = 0; Jalr = 0;
        zero = 0; less = 0; ALUResult = 32'd0; imm32 = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < (1 << C_AW); i++) rom[i] = $urandom;
        clear();
        rst = 1; preload = 0; chk_en = 0;
        @(posedge clk); #1; chk_en = 1;
        cyc(); rst = 0;
        @(negedge clk);
        check("boot instr_valid", {31'd0, instr_valid}, 32'd0);
        check("boot retired", retired, 32'd0);
        check("boot imem_addr", {18'd0, imem_addr}, 32'd0);
        cyc(); @(negedge clk);
        check("run0 instr_valid", {31'd0, instr_valid}, 32'd1);
        check("run0 pc", pc, 32'h0);
        check("run0 instr", instr, rom[0]);
        cyc(); @(negedge clk); check("seq pc 4", pc, 32'h4);
        cyc(); @(negedge clk); check("seq pc 8", pc, 32'h8);
        cyc(); cyc();
        Branch = 1; BranchType = 3'b000; zero = 1; imm32 = 32'hFFFF_FFF8;
        @(negedge clk);
        check("beq redirect", {31'd0, redirect}, 32'd1);
        check("beq retired before", retired, 32'd4);
        cyc(); clear(); @(negedge clk);
        check("beq target pc", pc, 32'h8);
        check("beq retired after", retired, 32'd5);
        repeat (6) cyc();
        Jump = 1; Jalr = 1; ALUResult = 32'h100;
        @(negedge clk);
        check("jalr pc", pc, 32'h20);
        check("jalr pc_plus4", pc_plus4, 32'h24);
        cyc(); ALUResult = 32'h20; @(negedge clk);
        check("jalr target pc", pc, 32'h100);
        cyc(); Jalr = 0; imm32 = 32'h40; @(negedge clk);
        check("back at 0x20", pc, 32'h20);
        cyc(); clear();
        Branch = 1; BranchType = 3'b101; less = 1; imm32 = 32'h10; stall = 1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            check("stall pc", pc, 32'h60);
            check("stall retired", retired, 32'd14);
            check("stall redirect", {31'd0, redirect}, 32'd0);
            check("stall instr", instr, rom[32'h60 >> 2]);
        end
        cyc(); stall = 0; @(negedge clk);
        check("bge redirect", {31'd0, redirect}, 32'd1);
        cyc(); clear(); @(negedge clk);
        check("bge target pc", pc, 32'h70);
        check("bge retired", retired, 32'd15);
        cyc(); Jump = 1; Jalr = 1; ALUResult = 32'h30; @(negedge clk);
        check("branch once pc", pc, 32'h74);
        cyc(); Jalr = 0; imm32 = 32'h6; @(negedge clk);
        check("jal site pc", pc, 32'h30);
        cyc(); clear(); @(negedge clk);
        check("halt misalign_err", {31'd0, misalign_err}, 32'd1);
        check("halt instr_valid", {31'd0, instr_valid}, 32'd0);
        check("halt pc", pc, 32'h30);
        check("halt retired", retired, 32'd17);
        cyc(); @(negedge clk);
        check("halt imem_addr", {18'd0, imem_addr}, 32'hC);
        cyc(); rst = 1;
        cyc(); rst = 0; @(negedge clk);
        check("restart misalign_err", {31'd0, misalign_err}, 32'd0);
        check("restart pc", pc, 32'h0);
        cyc(); Jump = 1; Jalr = 1; ALUResult = 32'hFFFF_FFFC;
        cyc(); clear();
        Branch = 1; BranchType = 3'b010; zero = 1; less = 1; preload = 1;
        @(negedge clk);
        check("top pc", pc, 32'hFFFF_FFFC);
        check("bt010 redirect", {31'd0, redirect}, 32'd0);
        check("top pc_plus4", pc_plus4, 32'h0);
        #2 force dut.r_retired = 32'hFFFF_FFFF;
        #1 release dut.r_retired;
        cyc(); preload = 0; clear(); @(negedge clk);
        check("wrap pc", pc, 32'h0);
        check("wrap retired", retired, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst        = (m_phase == P_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            Branch     = ($urandom_range(0, 2) == 0);
            BranchType = 3'($urandom_range(0, 7));
            Jump       = ($urandom_range(0, 7) == 0);
            Jalr       = 1'($urandom_range(0, 1));
            zero       = 1'($urandom_range(0, 1));
            less       = 1'($urandom_range(0, 1));
            ALUResult  = ($urandom_range(0, 19) == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom & 32'h0000_FFFC);
            imm32      = ($urandom_range(0, 29) == 0) ? $urandom
                                                      : 32'(($urandom_range(0, 63) - 32) * 4);
        end
        cyc(); clear(); rst = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
